// File: rtl/pkt_proc_pkg.sv
// Shared types and constants for the store-and-forward packet buffer.
// Sideband layout: each stored entry is {sideband[SB_W-1:0], data[DATA_W-1:0]},
// where sideband[SOP_BIT] marks the first beat and sideband[EOP_BIT] the last.
package pkt_proc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } wr_state_e;

    localparam int unsigned SOP_BIT = 0;
    localparam int unsigned EOP_BIT = 1;
    localparam int unsigned SB_W    = 2;
    localparam int unsigned STAT_W  = 16;

    // Saturating increment for the error statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/pkt_proc_sdp_ram.sv
// Simple dual-port RAM, one write port and one read port, registered read.
// Ports:
//   clk_i, rst_ni         clock, async active-low reset (read register only)
//   clr_i                 synchronous clear of the read register
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i          read request; rdata_o updates one cycle later and
//                         holds its value while re_i is low
//   rdata_o               registered read data
module pkt_proc_sdp_ram #(
    parameter  int unsigned DEPTH = 1024,
    parameter  int unsigned WIDTH = 34,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array; not reset, only committed entries are ever read.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register with hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pkt_proc_sf_buffer.sv
// Store-and-forward packet buffer. Beats are written speculatively at wr_ptr
// and only become readable once the packet's last beat commits (cptr moves up).
// Dropped, malformed or overflowing packets roll wr_ptr back to cptr.
// Ports:
//   pck_proc_int_mem_fsm_clk / _rstn / _sw_rstn   clock, async reset, sync soft reset
//   enq_req, in_sop, in_eop, wr_data_i            write beat
//   pck_len_valid, pck_len_i                      packet length, sampled with in_sop
//   deq_req                                       read one committed beat
//   rd_data_o, out_sop, out_eop                   registered read data + sideband
//   pck_proc_almost_full_value / _empty_value     thresholds
//   pck_proc_full/_empty/_almost_full/_almost_empty  status flags
//   pck_proc_overflow/_underflow, packet_drop     one-cycle pulses
//   pck_proc_wr_lvl                               total occupancy incl. uncommitted
// Optional: PKT_PROC_ERR_STATS_EN adds drop_cnt_o, ovf_cnt_o, udf_cnt_o
// (16-bit saturating event counters).
module pkt_proc_sf_buffer
    import pkt_proc_pkg::*;
#(
    parameter  int unsigned DATA_W        = 32,
    parameter  int unsigned DEPTH         = 1024,
    parameter  int unsigned LEN_W         = 12,
    parameter  int unsigned MAX_PKT_WORDS = 512,
    localparam int unsigned LVL_W         = $clog2(DEPTH) + 1
) (
    input  logic              pck_proc_int_mem_fsm_clk,
    input  logic              pck_proc_int_mem_fsm_rstn,
    input  logic              pck_proc_int_mem_fsm_sw_rstn,
    input  logic              enq_req,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              pck_len_valid,
    input  logic [LEN_W-1:0]  pck_len_i,
    input  logic              deq_req,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              out_sop,
    output logic              out_eop,
    input  logic [LVL_W-1:0]  pck_proc_almost_full_value,
    input  logic [LVL_W-1:0]  pck_proc_almost_empty_value,
    output logic              pck_proc_full,
    output logic              pck_proc_empty,
    output logic              pck_proc_almost_full,
    output logic              pck_proc_almost_empty,
    output logic              pck_proc_overflow,
    output logic              pck_proc_underflow,
    output logic              packet_drop,
    output logic [LVL_W-1:0]  pck_proc_wr_lvl
`ifdef PKT_PROC_ERR_STATS_EN
    ,
    output logic [STAT_W-1:0] drop_cnt_o,
    output logic [STAT_W-1:0] ovf_cnt_o,
    output logic [STAT_W-1:0] udf_cnt_o
`endif
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned ENT_W = DATA_W + SB_W;

    logic clk;
    logic rst_n;
    logic sw_rst;

    assign clk    = pck_proc_int_mem_fsm_clk;
    assign rst_n  = pck_proc_int_mem_fsm_rstn;
    assign sw_rst = !pck_proc_int_mem_fsm_sw_rstn;

    wr_state_e          state_q, state_d;
    logic [LVL_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]   cptr_q, cptr_d;
    logic [LVL_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               len_vld_q, len_vld_d;

    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               afull_q, afull_d;
    logic               aempty_q, aempty_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               drop_q, drop_d;
    logic [LVL_W-1:0]   wr_lvl_q, wr_lvl_d;

    logic [LVL_W-1:0]   wr_lvl;
    logic [LVL_W-1:0]   c_lvl;
    logic [LVL_W-1:0]   c_lvl_d;
    logic               full_now;
    logic               len_bad;
    logic               sop_len_err;
    logic               wr_len_err;
    logic [LEN_W-1:0]   cnt_inc;
    logic               ram_we;
    logic               rd_en;
    logic [SB_W-1:0]    sb_wr;
    logic [ENT_W-1:0]   ram_rdata;

    assign wr_lvl   = wr_ptr_q - rd_ptr_q;
    assign c_lvl    = cptr_q - rd_ptr_q;
    assign full_now = (wr_lvl == LVL_W'(DEPTH));
    assign cnt_inc  = cnt_q + LEN_W'(1);

    // Admission check on the first beat: zero, oversize, or not enough room.
    assign len_bad = (pck_len_i == '0)
                  || (32'(pck_len_i) > 32'(MAX_PKT_WORDS))
                  || (32'(pck_len_i) > (32'(DEPTH) - 32'(wr_lvl)));

    // Length mismatch for a single-beat view (first beat) and for later beats.
    assign sop_len_err = pck_len_valid && (in_eop ? (pck_len_i != LEN_W'(1))
                                                  : (pck_len_i == LEN_W'(1)));
    assign wr_len_err  = len_vld_q && (in_eop ? (cnt_inc != len_q)
                                              : (cnt_inc == len_q));

    // Write-side FSM: next state, pointers, write strobe and write pulses.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cptr_d    = cptr_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        len_vld_d = len_vld_q;
        ram_we    = 1'b0;
        drop_d    = 1'b0;
        ovf_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (enq_req) begin
                    if (!in_sop) begin
                        drop_d = 1'b1;
                    end else if (pck_len_valid && len_bad) begin
                        drop_d  = 1'b1;
                        state_d = in_eop ? IDLE : DROP;
                    end else if (full_now) begin
                        ovf_d   = 1'b1;
                        drop_d  = 1'b1;
                        state_d = in_eop ? IDLE : DROP;
                    end else if (sop_len_err) begin
                        drop_d  = 1'b1;
                        state_d = in_eop ? IDLE : DROP;
                    end else begin
                        ram_we    = 1'b1;
                        wr_ptr_d  = wr_ptr_q + LVL_W'(1);
                        cnt_d     = LEN_W'(1);
                        len_d     = pck_len_i;
                        len_vld_d = pck_len_valid;
                        if (in_eop) begin
                            cptr_d = wr_ptr_q + LVL_W'(1);
                        end else begin
                            state_d = WRITE;
                        end
                    end
                end
            end
            WRITE: begin
                if (enq_req) begin
                    if (in_sop) begin
                        wr_ptr_d = cptr_q;
                        drop_d   = 1'b1;
                        state_d  = in_eop ? IDLE : DROP;
                    end else if (full_now) begin
                        wr_ptr_d = cptr_q;
                        ovf_d    = 1'b1;
                        drop_d   = 1'b1;
                        state_d  = in_eop ? IDLE : DROP;
                    end else if (wr_len_err) begin
                        wr_ptr_d = cptr_q;
                        drop_d   = 1'b1;
                        state_d  = in_eop ? IDLE : DROP;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + LVL_W'(1);
                        cnt_d    = cnt_inc;
                        if (in_eop) begin
                            cptr_d  = wr_ptr_q + LVL_W'(1);
                            state_d = IDLE;
                        end
                    end
                end
            end
            DROP: begin
                if (enq_req && in_eop) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Soft reset discards everything, including any packet in flight.
        if (sw_rst) begin
            state_d   = IDLE;
            wr_ptr_d  = '0;
            cptr_d    = '0;
            cnt_d     = '0;
            len_d     = '0;
            len_vld_d = 1'b0;
            ram_we    = 1'b0;
            drop_d    = 1'b0;
            ovf_d     = 1'b0;
        end
    end

    // Read side and flags, all computed from next-state pointers.
    always_comb begin
        rd_en    = deq_req && (c_lvl != '0) && !sw_rst;
        udf_d    = deq_req && (c_lvl == '0) && !sw_rst;
        rd_ptr_d = rd_en ? rd_ptr_q + LVL_W'(1) : rd_ptr_q;
        if (sw_rst) begin
            rd_ptr_d = '0;
        end

        wr_lvl_d = wr_ptr_d - rd_ptr_d;
        c_lvl_d  = cptr_d - rd_ptr_d;
        full_d   = (wr_lvl_d == LVL_W'(DEPTH));
        empty_d  = (c_lvl_d == '0);
        afull_d  = (wr_lvl_d >= pck_proc_almost_full_value);
        aempty_d = (c_lvl_d <= pck_proc_almost_empty_value);

        if (sw_rst) begin
            full_d   = 1'b0;
            empty_d  = 1'b1;
            afull_d  = 1'b0;
            aempty_d = 1'b1;
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            cptr_q    <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            len_vld_q <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            drop_q    <= 1'b0;
            wr_lvl_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            cptr_q    <= cptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            len_vld_q <= len_vld_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            drop_q    <= drop_d;
            wr_lvl_q  <= wr_lvl_d;
        end
    end

    // Sideband packed alongside each data beat.
    always_comb begin
        sb_wr          = '0;
        sb_wr[SOP_BIT] = in_sop;
        sb_wr[EOP_BIT] = in_eop;
    end

    pkt_proc_sdp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_ram (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (sw_rst),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i ({sb_wr, wr_data_i}),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    assign rd_data_o             = ram_rdata[DATA_W-1:0];
    assign out_sop               = ram_rdata[DATA_W + SOP_BIT];
    assign out_eop               = ram_rdata[DATA_W + EOP_BIT];
    assign pck_proc_full         = full_q;
    assign pck_proc_empty        = empty_q;
    assign pck_proc_almost_full  = afull_q;
    assign pck_proc_almost_empty = aempty_q;
    assign pck_proc_overflow     = ovf_q;
    assign pck_proc_underflow    = udf_q;
    assign packet_drop           = drop_q;
    assign pck_proc_wr_lvl       = wr_lvl_q;

`ifdef PKT_PROC_ERR_STATS_EN
    logic [STAT_W-1:0] drop_cnt_q;
    logic [STAT_W-1:0] ovf_cnt_q;
    logic [STAT_W-1:0] udf_cnt_q;

    // Event counters track the pulses in the same cycle they appear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            ovf_cnt_q  <= '0;
            udf_cnt_q  <= '0;
        end else if (sw_rst) begin
            drop_cnt_q <= '0;
            ovf_cnt_q  <= '0;
            udf_cnt_q  <= '0;
        end else begin
            if (drop_d) drop_cnt_q <= sat_inc(drop_cnt_q);
            if (ovf_d)  ovf_cnt_q  <= sat_inc(ovf_cnt_q);
            if (udf_d)  udf_cnt_q  <= sat_inc(udf_cnt_q);
        end
    end

    assign drop_cnt_o = drop_cnt_q;
    assign ovf_cnt_o  = ovf_cnt_q;
    assign udf_cnt_o  = udf_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_proc_sf_buffer.sv
// Directed bench for pkt_proc_sf_buffer with a queue-based packet model and a
// per-cycle compare process, plus literal expectations per scenario.
module tb_pkt_proc_sf_buffer;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned DEPTH         = 16;
    localparam int unsigned LEN_W         = 12;
    localparam int unsigned MAX_PKT_WORDS = 8;
    localparam int unsigned LVL_W         = 5;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              sw_rstn = 1'b1;
    logic              enq = 1'b0, sop = 1'b0, eop = 1'b0, len_v = 1'b0, deq = 1'b0;
    logic [DATA_W-1:0] wdata = '0;
    logic [LEN_W-1:0]  len = '0;
    logic [LVL_W-1:0]  af_val = 5'd14;
    logic [LVL_W-1:0]  ae_val = 5'd1;

    logic [DATA_W-1:0] rd_data;
    logic              o_sop, o_eop, full, empty, afull, aempty, ovf, udf, drop;
    logic [LVL_W-1:0]  wr_lvl;
`ifdef PKT_PROC_ERR_STATS_EN
    logic [15:0]       drop_cnt, ovf_cnt, udf_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int drop_seen = 0;

    always #5 clk = ~clk;

    pkt_proc_sf_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .MAX_PKT_WORDS(MAX_PKT_WORDS)
    ) dut (
        .pck_proc_int_mem_fsm_clk     (clk),
        .pck_proc_int_mem_fsm_rstn    (rst_n),
        .pck_proc_int_mem_fsm_sw_rstn (sw_rstn),
        .enq_req                      (enq),
        .in_sop                       (sop),
        .in_eop                       (eop),
        .wr_data_i                    (wdata),
        .pck_len_valid                (len_v),
        .pck_len_i                    (len),
        .deq_req                      (deq),
        .rd_data_o                    (rd_data),
        .out_sop                      (o_sop),
        .out_eop                      (o_eop),
        .pck_proc_almost_full_value   (af_val),
        .pck_proc_almost_empty_value  (ae_val),
        .pck_proc_full                (full),
        .pck_proc_empty               (empty),
        .pck_proc_almost_full         (afull),
        .pck_proc_almost_empty        (aempty),
        .pck_proc_overflow            (ovf),
        .pck_proc_underflow           (udf),
        .packet_drop                  (drop),
        .pck_proc_wr_lvl              (wr_lvl)
`ifdef PKT_PROC_ERR_STATS_EN
        ,
        .drop_cnt_o                   (drop_cnt),
        .ovf_cnt_o                    (ovf_cnt),
        .udf_cnt_o                    (udf_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- packet-level model ----------------
    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              s;
        logic              e;
    } beat_t;

    beat_t cq[$];   // committed beats, readable
    beat_t pq[$];   // beats of the packet being received
    int    mode = 0; // 0: between packets, 1: receiving, 2: discarding to eop
    int    plen = 0;
    bit    plv  = 0;

    logic [DATA_W-1:0] m_rd = '0;
    bit m_sop = 0, m_eop = 0, m_ovf = 0, m_udf = 0, m_drop = 0;
    bit m_full = 0, m_empty = 1, m_af = 0, m_ae = 1;
    int m_wl = 0;

    function automatic void m_clear();
        cq.delete(); pq.delete();
        mode = 0; plen = 0; plv = 0;
        m_rd = '0; m_sop = 0; m_eop = 0;
        m_ovf = 0; m_udf = 0; m_drop = 0;
        m_full = 0; m_empty = 1; m_af = 0; m_ae = 1; m_wl = 0;
    endfunction

    function automatic void m_abort(input bit last);
        pq.delete();
        m_drop = 1;
        mode = last ? 0 : 2;
    endfunction

    function automatic void m_accept(input int wl0);
        beat_t b;
        int n;
        if (wl0 == int'(DEPTH)) begin
            m_ovf = 1;
            m_abort(eop);
            return;
        end
        b.d = wdata; b.s = (pq.size() == 0); b.e = eop;
        pq.push_back(b);
        n = pq.size();
        if (plv && ((eop && n != plen) || (!eop && n == plen))) begin
            m_abort(eop);
        end else if (eop) begin
            foreach (pq[i]) cq.push_back(pq[i]);
            pq.delete();
            mode = 0;
        end else begin
            mode = 1;
        end
    endfunction

    function automatic void m_step();
        int wl0 = cq.size() + pq.size();
        int c0  = cq.size();
        beat_t b;
        m_ovf = 0; m_udf = 0; m_drop = 0;
        if (enq) begin
            if (mode == 0) begin
                if (!sop) m_drop = 1;
                else if (len_v && (len == 0 || int'(len) > int'(MAX_PKT_WORDS)
                                   || int'(len) > int'(DEPTH) - wl0)) m_abort(eop);
                else begin
                    plen = int'(len); plv = len_v;
                    m_accept(wl0);
                end
            end else if (mode == 1) begin
                if (sop) m_abort(eop);
                else     m_accept(wl0);
            end else if (eop) begin
                mode = 0;
            end
        end
        if (deq) begin
            if (c0 > 0) begin
                b = cq.pop_front();
                m_rd = b.d; m_sop = b.s; m_eop = b.e;
            end else begin
                m_udf = 1;
            end
        end
        m_wl    = cq.size() + pq.size();
        m_full  = (m_wl == int'(DEPTH));
        m_empty = (cq.size() == 0);
        m_af    = (m_wl >= int'(af_val));
        m_ae    = (cq.size() <= int'(ae_val));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        m_clear();
        else if (!sw_rstn) m_clear();
        else               m_step();
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("cyc_rd_data", rd_data, m_rd);
        chk("cyc_out_sop", o_sop, m_sop);
        chk("cyc_out_eop", o_eop, m_eop);
        chk("cyc_full", full, m_full);
        chk("cyc_empty", empty, m_empty);
        chk("cyc_almost_full", afull, m_af);
        chk("cyc_almost_empty", aempty, m_ae);
        chk("cyc_overflow", ovf, m_ovf);
        chk("cyc_underflow", udf, m_udf);
        chk("cyc_packet_drop", drop, m_drop);
        chk("cyc_wr_lvl", wr_lvl, m_wl);
        if (drop === 1'b1) drop_seen++;
    end

    // ---------------- stimulus ----------------
    task automatic drv(input bit e, input bit s, input bit p, input logic [31:0] d,
                       input bit lv, input int l, input bit dq);
        @(posedge clk); #1;
        enq = e; sop = s; eop = p; wdata = d; len_v = lv; len = LEN_W'(l); deq = dq;
    endtask

    task automatic idle();
        drv(0, 0, 0, 32'h0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_almost_empty", aempty, 1);
        chk("rst_full", full, 0);
        chk("rst_wr_lvl", wr_lvl, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        idle();

        // 4-beat packet, len 4
        for (int i = 0; i < 4; i++) begin
            drv(1, i == 0, i == 3, 32'hA0 + i, i == 0, 4, 0);
            if (i > 0) chk("s1_empty_before_commit", empty, 1);
        end
        idle();
        chk("s1_empty_after_commit", empty, 0);
        chk("s1_wr_lvl", wr_lvl, 4);
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 0, 0, 0, 0, 1);
            idle();
            chk("s1_rd_data", rd_data, 32'hA0 + i);
            chk("s1_out_sop", o_sop, (i == 0));
            chk("s1_out_eop", o_eop, (i == 3));
        end
        chk("s1_empty_drained", empty, 1);

        // Simultaneous enq/deq, commit coinciding with an underflowing read
        drv(1, 1, 0, 32'hB0, 1, 2, 0);
        drv(1, 0, 1, 32'hB1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drv(1, i == 0, i == 2, 32'hC0 + i, 0, 0, 1);
        idle();
        for (int i = 0; i < 3; i++) drv(0, 0, 0, 0, 0, 0, 1);
        idle();
        chk("s1b_last_data", rd_data, 32'hC2);
        chk("s1b_last_eop", o_eop, 1);

        // len 5 but eop on beat 3
        drop_seen = 0;
        drv(1, 1, 0, 32'h50, 1, 5, 0);
        drv(1, 0, 0, 32'h51, 0, 0, 0);
        drv(1, 0, 1, 32'h52, 0, 0, 0);
        chk("s2_wr_lvl_mid", wr_lvl, 2);
        idle();
        idle();
        chk("s2_drop_count", drop_seen, 1);
        chk("s2_wr_lvl", wr_lvl, 0);
        chk("s2_empty", empty, 1);

        // Fill to 14 with two 7-beat packets, then a len-3 packet that cannot fit
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 7; i++)
                drv(1, i == 0, i == 6, 32'h100 + 16 * p + i, i == 0, 7, 0);
        idle();
        chk("s3_wr_lvl_14", wr_lvl, 14);
        chk("s3_almost_full", afull, 1);
        drop_seen = 0;
        drv(1, 1, 0, 32'h70, 1, 3, 0);
        drv(1, 0, 0, 32'h71, 0, 0, 0);
        chk("s3_drop_pulse", drop, 1);
        chk("s3_wr_lvl_hold", wr_lvl, 14);
        drv(1, 0, 1, 32'h72, 0, 0, 0);
        idle();
        idle();
        chk("s3_drop_count", drop_seen, 1);
        chk("s3_wr_lvl_after", wr_lvl, 14);

        // Single-beat packet to 15, then a packet with no length overflows
        drv(1, 1, 1, 32'hD0, 1, 1, 0);
        idle();
        chk("s4_wr_lvl_15", wr_lvl, 15);
        drv(1, 1, 0, 32'hF0, 0, 0, 0);
        drv(1, 0, 0, 32'hF1, 0, 0, 0);
        chk("s4_full", full, 1);
        chk("s4_wr_lvl_16", wr_lvl, 16);
        drv(1, 0, 1, 32'hF2, 0, 0, 0);
        chk("s4_overflow", ovf, 1);
        chk("s4_drop", drop, 1);
        chk("s4_wr_lvl_rollback", wr_lvl, 15);
        chk("s4_not_full", full, 0);
        idle();
        chk("s4_overflow_clear", ovf, 0);
        for (int i = 0; i < 15; i++) drv(0, 0, 0, 0, 0, 0, 1);
        idle();
        chk("s4_last_data", rd_data, 32'hD0);
        chk("s4_last_sop", o_sop, 1);
        chk("s4_empty", empty, 1);

        // Underflow leaves read data untouched
        drv(0, 0, 0, 0, 0, 0, 1);
        idle();
        chk("s5_underflow", udf, 1);
        chk("s5_rd_data_hold", rd_data, 32'hD0);
        idle();
        chk("s5_underflow_clear", udf, 0);

        // Soft reset with one committed packet and one partial packet
        drv(1, 1, 0, 32'hE0, 1, 2, 0);
        drv(1, 0, 1, 32'hE1, 0, 0, 0);
        drv(1, 1, 0, 32'hE2, 1, 3, 0);
        idle();
        sw_rstn = 1'b0;
        idle();
        sw_rstn = 1'b1;
        chk("s6_sw_wr_lvl", wr_lvl, 0);
        chk("s6_sw_empty", empty, 1);
        chk("s6_sw_rd_data", rd_data, 0);

        // Async reset in the middle of a packet
        drv(1, 1, 0, 32'h60, 1, 3, 0);
        drv(1, 0, 0, 32'h61, 0, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        enq = 0; sop = 0; eop = 0; len_v = 0; deq = 0;
        #1;
        chk("s7_rst_wr_lvl", wr_lvl, 0);
        chk("s7_rst_empty", empty, 1);
        chk("s7_rst_aempty", aempty, 1);
        chk("s7_rst_afull", afull, 0);
        chk("s7_rst_drop", drop, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        drv(1, 1, 0, 32'h90, 1, 2, 0);
        drv(1, 0, 1, 32'h91, 0, 0, 0);
        idle();
        chk("s7_wr_lvl", wr_lvl, 2);
        chk("s7_empty", empty, 0);
        for (int i = 0; i < 2; i++) begin
            drv(0, 0, 0, 0, 0, 0, 1);
            idle();
            chk("s7_rd_data", rd_data, 32'h90 + i);
            chk("s7_out_sop", o_sop, (i == 0));
            chk("s7_out_eop", o_eop, (i == 1));
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
